clock_display_scan: RTL and testbench

Downstream display stage for `digital_clock`. Consumes the binary `hr`/`min`/`sec` time and the `alarm_active` flag. Drives a six-digit, time-multiplexed, common-enable 7-segment display (HH.MM.SS). It snapshots the time once per scan frame, converts each field to BCD, decodes to segments and scans one digit at a time, with optional display blink while the alarm is active.

---
 rtl/clock_display_scan.sv | 174 +++++++++++++++++
 tb/tb_clock_display_scan.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed 7-segment scanner for HH.MM.SS with per-frame snapshot and BCD decode.
// Optional alarm blink is compiled in when ALARM_BLINK_EN is defined.
module clock_display_scan #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] hr,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       alarm_active,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SCNT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SCNT_LIT  = SW'(2);
    localparam logic [6:0]    SEG_DASH  = 7'h40;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h3F;
            4'd1:    seg_of = 7'h06;
            4'd2:    seg_of = 7'h5B;
            4'd3:    seg_of = 7'h4F;
            4'd4:    seg_of = 7'h66;
            4'd5:    seg_of = 7'h6D;
            4'd6:    seg_of = 7'h7D;
            4'd7:    seg_of = 7'h07;
            4'd8:    seg_of = 7'h7F;
            4'd9:    seg_of = 7'h6F;
            default: seg_of = 7'h00;
        endcase
    endfunction

    logic [SW-1:0] r_scnt;
    logic [2:0]    r_idx;
    logic [4:0]    r_sh_hr;
    logic [5:0]    r_sh_min;
    logic [5:0]    r_sh_sec;
    logic [3:0]    r_sec_u, r_sec_t, r_min_u, r_min_t, r_hr_u, r_hr_t;
    logic          r_sec_bad, r_min_bad, r_hr_bad;
    logic          w_wrap;
    logic          w_dark;
    logic [6:0]    w_code;

    assign w_wrap = (r_scnt == SCNT_LAST) && (r_idx == 3'd5);

    // Slot counter and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scnt <= '0;
            r_idx  <= 3'd0;
        end else if (r_scnt == SCNT_LAST) begin
            r_scnt <= '0;
            r_idx  <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_scnt <= r_scnt + SW'(1);
        end
    end

    // Frame snapshot: captured only on the 5->0 wrap so a frame is coherent
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_hr  <= 5'd0;
            r_sh_min <= 6'd0;
            r_sh_sec <= 6'd0;
        end else if (w_wrap) begin
            r_sh_hr  <= hr;
            r_sh_min <= min;
            r_sh_sec <= sec;
        end else begin
            r_sh_hr  <= r_sh_hr;
            r_sh_min <= r_sh_min;
            r_sh_sec <= r_sh_sec;
        end
    end

    // BCD split and range flags; the one-cycle latency is hidden by the dead slots
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sec_u   <= 4'd0;
            r_sec_t   <= 4'd0;
            r_min_u   <= 4'd0;
            r_min_t   <= 4'd0;
            r_hr_u    <= 4'd0;
            r_hr_t    <= 4'd0;
            r_sec_bad <= 1'b0;
            r_min_bad <= 1'b0;
            r_hr_bad  <= 1'b0;
        end else begin
            r_sec_u   <= 4'(r_sh_sec % 6'd10);
            r_sec_t   <= 4'(r_sh_sec / 6'd10);
            r_min_u   <= 4'(r_sh_min % 6'd10);
            r_min_t   <= 4'(r_sh_min / 6'd10);
            r_hr_u    <= 4'(r_sh_hr % 5'd10);
            r_hr_t    <= 4'(r_sh_hr / 5'd10);
            r_sec_bad <= (r_sh_sec > 6'd59);
            r_min_bad <= (r_sh_min > 6'd59);
            r_hr_bad  <= (r_sh_hr > 5'd23);
        end
    end

`ifdef ALARM_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] r_bcnt;
    logic          r_bph;

    // Blink phase runs only while the alarm rings, otherwise held cleared
    always_ff @(posedge clk) begin
        if (rst || !alarm_active) begin
            r_bcnt <= '0;
            r_bph  <= 1'b0;
        end else if (r_bcnt == BCNT_LAST) begin
            r_bcnt <= '0;
            r_bph  <= ~r_bph;
        end else begin
            r_bcnt <= r_bcnt + BW'(1);
            r_bph  <= r_bph;
        end
    end

    assign w_dark = r_bph & alarm_active;
`else
    logic w_unused_alarm;
    assign w_unused_alarm = alarm_active;
    assign w_dark         = 1'b0;
`endif

    // Segment pattern for the current digit; hours-tens zero is blanked
    always_comb begin
        w_code = 7'h00;
        case (r_idx)
            3'd0: w_code = r_sec_bad ? SEG_DASH : seg_of(r_sec_u);
            3'd1: w_code = r_sec_bad ? SEG_DASH : seg_of(r_sec_t);
            3'd2: w_code = r_min_bad ? SEG_DASH : seg_of(r_min_u);
            3'd3: w_code = r_min_bad ? SEG_DASH : seg_of(r_min_t);
            3'd4: w_code = r_hr_bad  ? SEG_DASH : seg_of(r_hr_u);
            3'd5: begin
                if (r_hr_bad) begin
                    w_code = SEG_DASH;
                end else if (r_hr_t == 4'd0) begin
                    w_code = 7'h00;
                end else begin
                    w_code = seg_of(r_hr_t);
                end
            end
            default: w_code = 7'h00;
        endcase
    end

    // Registered display drive with dead time at the start of each slot
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 6'd0;
            seg <= 7'h00;
            dp  <= 1'b0;
        end else if ((r_scnt >= SCNT_LIT) && !w_dark) begin
            an  <= 6'b000001 << r_idx;
            seg <= w_code;
            dp  <= (r_idx == 3'd2) || (r_idx == 3'd4);
        end else begin
            an  <= 6'd0;
            seg <= 7'h00;
            dp  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: directed steps plus random inputs, checked every cycle
// against a frame/slot arithmetic model of the display.
module tb_clock_display_scan;

    localparam int SD    = 4;
    localparam int BD    = 8;
    localparam int FRAME = 6 * SD;
`ifdef ALARM_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] t_hr;
    logic [5:0] t_min;
    logic [5:0] t_sec;
    logic       t_alarm;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int total = 0;
    int bad   = 0;

    // model state
    int c    = 0;
    int arun = 0;
    int snap_hr = 0, snap_min = 0, snap_sec = 0;
    logic [5:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    bit         chk_all;

    clock_display_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst(rst), .hr(t_hr), .min(t_min), .sec(t_sec),
        .alarm_active(t_alarm), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] digit_code(input int d);
        logic [6:0] tbl [10];
        int v, lim, dig;
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        v   = (d < 2) ? snap_sec : (d < 4) ? snap_min : snap_hr;
        lim = (d < 4) ? 59 : 23;
        dig = (d % 2 == 0) ? v % 10 : v / 10;
        if (v > lim) return 7'h40;
        if (d == 5 && dig == 0) return 7'h00;
        return tbl[dig];
    endfunction

    task automatic tick();
        int pos, d, s;
        bit dark;
        @(posedge clk);
        if (rst) begin
            c = 0; arun = 0;
            snap_hr = 0; snap_min = 0; snap_sec = 0;
            exp_an = 6'd0; exp_seg = 7'h00; exp_dp = 1'b0; chk_all = 1'b1;
        end else begin
            c++;
            pos  = (c - 1) % FRAME;
            d    = pos / SD;
            s    = pos % SD;
            arun = t_alarm ? arun + 1 : 0;
            dark = BLINK_ON && t_alarm && ((((arun - 1) / BD) % 2) == 1);
            if (s >= 2 && !dark) begin
                exp_an  = 6'(1 << d);
                exp_seg = digit_code(d);
                exp_dp  = (d == 2) || (d == 4);
                chk_all = 1'b1;
            end else begin
                exp_an  = 6'd0;
                chk_all = 1'b0;
            end
            if (c % FRAME == 0) begin
                snap_hr = int'(t_hr); snap_min = int'(t_min); snap_sec = int'(t_sec);
            end
        end
        #1;
        total++;
        assert (an === exp_an) else begin
            bad++;
            $error("FAIL an c=%0d observed=%b expected=%b", c, an, exp_an);
        end
        if (chk_all) begin
            total++;
            assert (seg === exp_seg) else begin
                bad++;
                $error("FAIL seg c=%0d observed=%h expected=%h", c, seg, exp_seg);
            end
            total++;
            assert (dp === exp_dp) else begin
                bad++;
                $error("FAIL dp c=%0d observed=%b expected=%b", c, dp, exp_dp);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        t_hr = 5'(h); t_min = 6'(m); t_sec = 6'(s);
    endtask

    task automatic run_to_phase(input int ph);
        for (int i = 0; i < FRAME; i++) begin
            if (c % FRAME == ph) break;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; t_alarm = 1'b0;
        set_time(0, 0, 0);
        // reset held 3 cycles, then first frame of zeros
        run(3);
        rst = 1'b0;
        run(FRAME);

        // static 12:34:56
        set_time(12, 34, 56);
        run(2 * FRAME);

        // snapshot coherence: 23:59:59 then 00:00:00 while idx = 3
        set_time(23, 59, 59);
        run_to_phase(0);
        run(FRAME);
        run_to_phase(3 * SD + 1);
        set_time(0, 0, 0);
        run(2 * FRAME);

        // out of range minutes
        set_time(7, 60, 0);
        run(2 * FRAME);

        // mid-frame reset at idx = 4
        set_time(9, 8, 7);
        run(FRAME);
        run_to_phase(4 * SD + 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(2 * FRAME);

        // alarm blink (steady in the default build)
        t_alarm = 1'b1;
        run(5 * BD + 3);
        t_alarm = 1'b0;
        run(FRAME);

        // random inputs including out-of-range values and occasional reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) set_time($urandom_range(31), $urandom_range(63), $urandom_range(63));
            if ($urandom_range(40) == 0) t_alarm = ~t_alarm;
            rst = ($urandom_range(200) == 0);
            tick();
        end
        rst = 1'b0;
        run(FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
